// File: rtl/multi_timer.sv
// N-channel prescaled down-counting timer with sticky per-channel pending flags and one OR-ed interrupt line.
// Reads are combinational and writes are registered; the bus is never stalled, so there is no backpressure.
module multi_timer #(
   parameter int N_CH  = 4,
   parameter int WIDTH = 32,
   parameter int AW    = $clog2(N_CH) + 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [AW-1:0]   Addr,
   input  logic            Write_Enabled,
   input  logic [31:0]     Data_In,
   output logic [31:0]     Data_Out,
   output logic [N_CH-1:0] irq_vec,
   output logic            INT_REQ
);

   typedef enum logic [1:0] {IDLE, LOAD, COUNTING, EXPIRE} state_e;

   state_e           state_q   [N_CH];
   state_e           state_d   [N_CH];
   logic             en_q      [N_CH];
   logic             en_d      [N_CH];
   logic [1:0]       mode_q    [N_CH];
   logic [1:0]       mode_d    [N_CH];
   logic             im_q      [N_CH];
   logic             im_d      [N_CH];
   logic [7:0]       psc_q     [N_CH];
   logic [7:0]       psc_d     [N_CH];
   logic [7:0]       psc_lat_q [N_CH];
   logic [7:0]       psc_lat_d [N_CH];
   logic [7:0]       psc_cnt_q [N_CH];
   logic [7:0]       psc_cnt_d [N_CH];
   logic [WIDTH-1:0] preset_q  [N_CH];
   logic [WIDTH-1:0] preset_d  [N_CH];
   logic [WIDTH-1:0] count_q   [N_CH];
   logic [WIDTH-1:0] count_d   [N_CH];
   logic             pend_q    [N_CH];
   logic             pend_d    [N_CH];
   logic             pend_set  [N_CH];
   logic             wr_hit    [N_CH];

   // Channel field kept AW bits wide so a single-channel build (no channel bits) still decodes.
   logic [AW-1:0] sel_ch;
   assign sel_ch = Addr >> 2;

   logic unused_din;
   assign unused_din = ^Data_In;

   always_comb begin
      for (int c = 0; c < N_CH; c++) begin
         state_d[c]   = state_q[c];
         en_d[c]      = en_q[c];
         mode_d[c]    = mode_q[c];
         im_d[c]      = im_q[c];
         psc_d[c]     = psc_q[c];
         psc_lat_d[c] = psc_lat_q[c];
         psc_cnt_d[c] = psc_cnt_q[c];
         preset_d[c]  = preset_q[c];
         count_d[c]   = count_q[c];
         pend_d[c]    = pend_q[c];
         pend_set[c]  = 1'b0;
         wr_hit[c]    = Write_Enabled && (sel_ch == AW'(c));

         if (!en_q[c]) begin
            state_d[c]   = IDLE;
            psc_cnt_d[c] = '0;
         end else begin
            case (state_q[c])
               IDLE: state_d[c] = LOAD;
               LOAD: begin
                  // Prescale is latched here so mid-count PSC writes wait for the next load.
                  count_d[c]   = preset_q[c];
                  psc_cnt_d[c] = '0;
                  psc_lat_d[c] = psc_q[c];
                  state_d[c]   = (preset_q[c] == '0) ? EXPIRE : COUNTING;
               end
               COUNTING: begin
                  if (psc_cnt_q[c] == psc_lat_q[c]) begin
                     psc_cnt_d[c] = '0;
                     if (count_q[c] != '0) count_d[c] = count_q[c] - WIDTH'(1);
                     if (count_q[c] <= WIDTH'(1)) state_d[c] = EXPIRE;
                  end else begin
                     psc_cnt_d[c] = psc_cnt_q[c] + 8'd1;
                  end
               end
               EXPIRE: begin
                  pend_set[c] = 1'b1;
                  if (mode_q[c] == 2'b01) begin
                     state_d[c] = LOAD;
                  end else begin
                     en_d[c]    = 1'b0;
                     state_d[c] = IDLE;
                  end
               end
               default: state_d[c] = IDLE;
            endcase
         end

         // Software writes land after the FSM so a CTRL write beats the one-shot enable clear.
         if (wr_hit[c]) begin
            case (Addr[1:0])
               2'd0: begin
                  en_d[c]   = Data_In[0];
                  mode_d[c] = Data_In[2:1];
                  im_d[c]   = Data_In[3];
                  psc_d[c]  = Data_In[11:4];
               end
               2'd1: preset_d[c] = Data_In[WIDTH-1:0];
               2'd3: if (Data_In[0]) pend_d[c] = 1'b0;
               default: ;
            endcase
         end
         if (pend_set[c]) pend_d[c] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int c = 0; c < N_CH; c++) begin
            state_q[c]   <= IDLE;
            en_q[c]      <= 1'b0;
            mode_q[c]    <= 2'b00;
            im_q[c]      <= 1'b0;
            psc_q[c]     <= '0;
            psc_lat_q[c] <= '0;
            psc_cnt_q[c] <= '0;
            preset_q[c]  <= '0;
            count_q[c]   <= '0;
            pend_q[c]    <= 1'b0;
         end
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            state_q[c]   <= state_d[c];
            en_q[c]      <= en_d[c];
            mode_q[c]    <= mode_d[c];
            im_q[c]      <= im_d[c];
            psc_q[c]     <= psc_d[c];
            psc_lat_q[c] <= psc_lat_d[c];
            psc_cnt_q[c] <= psc_cnt_d[c];
            preset_q[c]  <= preset_d[c];
            count_q[c]   <= count_d[c];
            pend_q[c]    <= pend_d[c];
         end
      end
   end

   always_comb begin
      Data_Out = '0;
      for (int c = 0; c < N_CH; c++) begin
         if (sel_ch == AW'(c)) begin
            case (Addr[1:0])
               2'd0:    Data_Out = {20'b0, psc_q[c], im_q[c], mode_q[c], en_q[c]};
               2'd1:    Data_Out = 32'(preset_q[c]);
               2'd2:    Data_Out = 32'(count_q[c]);
               default: Data_Out = {31'b0, pend_q[c]};
            endcase
         end
      end
   end

   always_comb begin
      irq_vec = '0;
      for (int c = 0; c < N_CH; c++) irq_vec[c] = pend_q[c] & im_q[c];
   end

   assign INT_REQ = |irq_vec;

endmodule
